// File: rtl/rs232_tx_pkg.sv
// rtl/rs232_tx_pkg.sv - register map, bit indices and FSM states for the RS-232 transmitter (RS232_TX_PARITY_EN adds ST_PARITY)
package rs232_tx_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_DIVISOR = 2'd2;
    localparam logic [1:0] ADDR_CONTROL = 2'd3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_LEVEL_LSB = 4;
    localparam int STAT_LEVEL_W   = 5;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IE     = 1;
    localparam int CTRL_ODD    = 2;
    localparam int CTRL_FLUSH  = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef RS232_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/rs232_tx_fifo.sv
// rtl/rs232_tx_fifo.sv - byte FIFO with push-while-full-and-popping and single-cycle flush
module rs232_tx_fifo #(
    parameter int DEPTH   = 8,
    parameter int LEVEL_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_push,
    input  logic [7:0]         i_wdata,
    input  logic               i_pop,
    input  logic               i_flush,
    output logic [7:0]         o_rdata,
    output logic               o_full,
    output logic               o_empty,
    output logic [LEVEL_W-1:0] o_level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]      PTR_ONE  = AW'(1);
    localparam logic [LEVEL_W-1:0] LVL_ONE  = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] LVL_FULL = LEVEL_W'(DEPTH);

    logic [7:0]         r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LEVEL_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // A full FIFO still takes a byte when the head leaves in the same cycle; flush discards any push
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == LVL_FULL);
    assign o_empty = (r_count == '0);
    assign o_level = r_count;

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; flush resets everything in one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + LVL_ONE;
                2'b01:   r_count <= r_count - LVL_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rs232_tx_ctrl.sv
// rtl/rs232_tx_ctrl.sv - Avalon-MM RS-232 transmitter with TX FIFO; RS232_TX_PARITY_EN enables the parity bit
module rs232_tx_ctrl
    import rs232_tx_pkg::*;
#(
    parameter int FIFO_DEPTH      = 8,
    parameter int CLK_DIV_DEFAULT = 433
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        txd,
    output logic        irq
);

    tx_state_t   r_state;
    logic        r_txd;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_data;
    logic [15:0] r_divisor;
    logic        r_enable;
    logic        r_ie;
    logic        r_overflow;
`ifdef RS232_TX_PARITY_EN
    logic        r_odd;
    logic        w_parity;
`endif

    logic        w_wr;
    logic        w_rd;
    logic        w_data_wr;
    logic        w_ctrl_wr;
    logic        w_stat_rd;
    logic        w_flush;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_rdata;
    logic [STAT_LEVEL_W-1:0] w_level;
    logic        w_bit_end;
    logic        w_can_start;
    logic        w_busy;
    logic [2:0]  w_next_idx;
    logic        w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_rd      = chipselect & ~read_n;
    assign w_data_wr = w_wr & (address == ADDR_DATA);
    assign w_ctrl_wr = w_wr & (address == ADDR_CONTROL);
    assign w_stat_rd = w_rd & (address == ADDR_STATUS);
    assign w_flush   = w_ctrl_wr & writedata[CTRL_FLUSH];
    assign w_unused  = ^writedata[31:16];

    assign w_bit_end   = (r_baud_cnt == 16'd0);
    assign w_can_start = r_enable & ~w_empty;
    assign w_busy      = (r_state != ST_IDLE);
    assign w_next_idx  = r_bit_cnt + 3'd1;

    // The head byte leaves the FIFO exactly when a frame is launched
    assign w_pop = w_can_start & ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_bit_end));

`ifdef RS232_TX_PARITY_EN
    assign w_parity = (^r_data) ^ r_odd;
`endif

    assign txd = r_txd;
    assign irq = w_empty & ~w_busy & r_ie;

    rs232_tx_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .LEVEL_W (STAT_LEVEL_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_data_wr),
        .i_wdata (writedata[7:0]),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Programmable registers and the sticky overflow flag (a new overflow beats a clearing read)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_divisor  <= 16'(CLK_DIV_DEFAULT);
            r_enable   <= 1'b0;
            r_ie       <= 1'b0;
            r_overflow <= 1'b0;
`ifdef RS232_TX_PARITY_EN
            r_odd      <= 1'b0;
`endif
        end else begin
            if (w_wr && address == ADDR_DIVISOR) begin
                r_divisor <= writedata[15:0];
            end
            if (w_ctrl_wr) begin
                r_enable <= writedata[CTRL_ENABLE];
                r_ie     <= writedata[CTRL_IE];
`ifdef RS232_TX_PARITY_EN
                r_odd    <= writedata[CTRL_ODD];
`endif
            end
            if (w_data_wr && w_full && !w_pop && !w_flush) begin
                r_overflow <= 1'b1;
            end else if (w_stat_rd) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Frame sequencer: txd is registered, baud counter reloads from DIVISOR only at bit boundaries
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_txd      <= 1'b1;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
            r_data     <= 8'd0;
        end else begin
            if (r_state != ST_IDLE) begin
                r_baud_cnt <= w_bit_end ? r_divisor : (r_baud_cnt - 16'd1);
            end
            case (r_state)
                ST_IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_state    <= ST_START;
                        r_txd      <= 1'b0;
                        r_data     <= w_rdata;
                        r_baud_cnt <= r_divisor;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_state   <= ST_DATA;
                        r_txd     <= r_data[0];
                        r_bit_cnt <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == 3'd7) begin
`ifdef RS232_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            r_txd   <= w_parity;
`else
                            r_state <= ST_STOP;
                            r_txd   <= 1'b1;
`endif
                        end else begin
                            r_bit_cnt <= w_next_idx;
                            r_txd     <= r_data[w_next_idx];
                        end
                    end
                end
`ifdef RS232_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                        r_txd   <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_state <= ST_START;
                            r_txd   <= 1'b0;
                            r_data  <= w_rdata;
                        end else begin
                            r_state <= ST_IDLE;
                            r_txd   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    // Zero-wait-state read mux
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_STATUS: begin
                readdata[STAT_BUSY]     = w_busy;
                readdata[STAT_FULL]     = w_full;
                readdata[STAT_EMPTY]    = w_empty;
                readdata[STAT_OVERFLOW] = r_overflow;
                readdata[STAT_LEVEL_LSB +: STAT_LEVEL_W] = w_level;
            end
            ADDR_DIVISOR: readdata[15:0] = r_divisor;
            ADDR_CONTROL: begin
                readdata[CTRL_ENABLE] = r_enable;
                readdata[CTRL_IE]     = r_ie;
`ifdef RS232_TX_PARITY_EN
                readdata[CTRL_ODD]    = r_odd;
`endif
            end
            default: readdata = 32'd0;
        endcase
    end

endmodule
